// File: rtl/pipe_skid_reg.sv
// Elastic valid/ready pipeline register with a skid buffer: full throughput,
// and the upstream ready is decoded from registered state only.
module pipe_skid_reg #(
    parameter int unsigned DWIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DWIDTH-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DWIDTH-1:0] out_data_o,
    input  logic              flush_i,
    output logic [1:0]        count_o
);

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] FULL  = 2'd2;

    logic [1:0]        state;
    logic [1:0]        state_next;
    logic [DWIDTH-1:0] main;
    logic [DWIDTH-1:0] main_next;
    logic [DWIDTH-1:0] skid;
    logic [DWIDTH-1:0] skid_next;
    logic              accept;
    logic              fire;

    assign in_ready_o  = (state != FULL);
    assign out_valid_o = (state != EMPTY);
    assign out_data_o  = main;
    assign accept      = in_valid_i & in_ready_o;
    assign fire        = out_valid_o & out_ready_i;

    always_comb begin
        count_o = 2'd0;
        case (state)
            ONE:     count_o = 2'd1;
            FULL:    count_o = 2'd2;
            default: count_o = 2'd0;
        endcase
    end

    always_comb begin
        state_next = state;
        main_next  = main;
        skid_next  = skid;
        case (state)
            EMPTY: begin
                if (accept) begin
                    state_next = ONE;
                    main_next  = in_data_i;
                end
            end
            ONE: begin
                if (accept && fire) begin
                    main_next = in_data_i;
                end else if (accept) begin
                    state_next = FULL;
                    skid_next  = in_data_i;
                end else if (fire) begin
                    state_next = EMPTY;
                end
            end
            FULL: begin
                if (fire) begin
                    state_next = ONE;
                    main_next  = skid;
                end
            end
            default: begin
                // unreachable encoding recovers to a clean empty state
                state_next = EMPTY;
                main_next  = '0;
                skid_next  = '0;
            end
        endcase
        if (flush_i) begin
            state_next = EMPTY;
            main_next  = '0;
            skid_next  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
            main  <= '0;
            skid  <= '0;
        end else begin
            state <= state_next;
            main  <= main_next;
            skid  <= skid_next;
        end
    end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Self-checking bench for pipe_skid_reg: directed vectors with hand-computed
// expectations, then a randomized run against a queue model.
module tb_pipe_skid_reg;

    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          flush;
    logic [1:0]    count;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    pipe_skid_reg #(.DWIDTH(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_data),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .flush_i     (flush),
        .count_o     (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // advance one clock; inputs are then changed and outputs sampled 1 time unit later
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_state(input string tag, input logic [1:0] cnt, input logic [DW-1:0] data);
        check({tag, ".count"}, 32'(count), 32'(cnt));
        check({tag, ".valid"}, 32'(out_valid), 32'(cnt != 2'd0));
        check({tag, ".ready"}, 32'(in_ready), 32'(cnt != 2'd2));
        check({tag, ".data"}, out_data, data);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1, "watchdog expired");
    end

    logic [DW-1:0] model_q[$];
    logic          m_accept;
    logic          m_fire;

    initial begin
        rst = 1'b1; in_valid = 1'b1; in_data = 32'h55; out_ready = 1'b0; flush = 1'b0;

        // 1: reset with upstream pushing
        step();
        expect_state("rst0", 2'd0, '0);
        step();
        expect_state("rst1", 2'd0, '0);
        rst = 1'b0; in_valid = 1'b0;
        step();
        expect_state("rst_rel", 2'd0, '0);

        // 2: streaming at one word per clock
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1; in_data = 32'(i);
            step();
            expect_state($sformatf("stream%0d", i), 2'd1, 32'(i));
        end
        in_valid = 1'b0;
        step();
        expect_state("stream_drain", 2'd0, 32'h8);

        // 3: backpressure fills the skid and holds off the third word
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'hA;
        step();
        expect_state("bp_a", 2'd1, 32'hA);
        in_data = 32'hB;
        step();
        expect_state("bp_b", 2'd2, 32'hA);
        in_data = 32'hC;
        step();
        expect_state("bp_stall", 2'd2, 32'hA);
        out_ready = 1'b1;
        step();
        expect_state("bp_out_b", 2'd1, 32'hB);
        step();
        expect_state("bp_out_c", 2'd1, 32'hC);
        in_valid = 1'b0;
        step();
        expect_state("bp_drain", 2'd0, 32'hC);

        // 4: fire while FULL does not accept; word taken on the following cycle
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h11;
        step();
        in_data = 32'h12;
        step();
        expect_state("sim_full", 2'd2, 32'h11);
        out_ready = 1'b1; in_data = 32'hD;
        step();
        expect_state("sim_fire", 2'd1, 32'h12);
        out_ready = 1'b0;
        step();
        expect_state("sim_acc_d", 2'd2, 32'h12);
        out_ready = 1'b1; in_valid = 1'b0;
        step();
        expect_state("sim_out_d", 2'd1, 32'hD);
        step();
        expect_state("sim_drain", 2'd0, 32'hD);

        // 5: flush dominates a same-cycle accept
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h21;
        step();
        in_data = 32'h22;
        step();
        expect_state("fl_full", 2'd2, 32'h21);
        flush = 1'b1; in_data = 32'hE;
        step();
        expect_state("fl_flush", 2'd0, '0);
        flush = 1'b0; in_data = 32'hF; out_ready = 1'b1;
        step();
        expect_state("fl_next", 2'd1, 32'hF);
        in_valid = 1'b0;
        step();
        expect_state("fl_drain", 2'd0, 32'hF);

        // reset mid-stream discards both held words, beating flush and transfers
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h31;
        step();
        in_data = 32'h32;
        step();
        expect_state("rs_full", 2'd2, 32'h31);
        rst = 1'b1; flush = 1'b1; out_ready = 1'b1;
        step();
        expect_state("rs_reset", 2'd0, '0);
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
        step();
        expect_state("rs_idle", 2'd0, '0);

        // 6: random traffic against a queue model
        for (int c = 0; c < 10000; c++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            in_data   = $urandom;
            check("rnd.ready", 32'(in_ready), 32'(model_q.size() < 2));
            check("rnd.valid", 32'(out_valid), 32'(model_q.size() != 0));
            if (model_q.size() != 0) check("rnd.data", out_data, model_q[0]);
            m_accept = in_valid && (model_q.size() < 2);
            m_fire   = out_ready && (model_q.size() != 0);
            if (m_fire) void'(model_q.pop_front());
            if (m_accept) model_q.push_back(in_data);
            step();
            check("rnd.count", 32'(count), 32'(model_q.size()));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
